cic_decim_ctrl: RTL and testbench
=================================

CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 Parameter WordLengthBits, 12: sample width, matching the comb stage word length.
REQ-002 Parameter RateBits, 8: width of the decimation-ratio input.
REQ-003 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port enable, input, 1: run request.
REQ-006 Port rate, input, RateBits: decimation ratio R; 0 treated as 1.
REQ-007 Port in, input, WordLengthBits signed: integrator-side sample.
REQ-008 Port in_valid, input, 1: sample present.
REQ-009 Port in_ready, output, 1: controller accepts sample this cycle.
REQ-010 Port comb_in, output, WordLengthBits signed: held decimated sample to comb.
REQ-011 Port comb_in_valid, output, 1: one-cycle strobe to comb in_valid.
REQ-012 Port comb_out_valid, input, 1: comb output valid.
REQ-013 Port comb_out_ready, output, 1: combinational copy of out_ready.
REQ-014 Port out_valid, output, 1: combinational copy of comb_out_valid.
REQ-015 Port out_ready, input, 1: downstream ready.
REQ-016 Port overrun_count, output, 16: dropped-sample counter (see Configuration).

Function
REQ-017 Accept = in_valid && in_ready, evaluated at the rising edge.
REQ-018 States IDLE, COUNT, FIRE, HOLD; in_ready high only in COUNT.
REQ-019 IDLE: when enable=1, latch R_lat = max(rate,1), clear phase counter, go to COUNT next cycle.
REQ-020 COUNT: each accept increments phase; on the accept making phase == R_lat, register in into comb_in, clear phase, go to FIRE.
REQ-021 FIRE: comb_in_valid=1 for exactly one cycle; next state HOLD unconditionally.
REQ-022 HOLD: stay until comb_out_valid && out_ready; then COUNT if enable=1, else IDLE.
REQ-023 Latency: Rth accepted sample at edge N gives comb_in_valid high during cycle N+1.
REQ-024 rate changes outside IDLE are ignored until the next IDLE->COUNT transition.
REQ-025 enable dropped in COUNT: go IDLE next cycle, discard the partial phase; dropped in FIRE/HOLD: complete the sequence, then IDLE.
REQ-026 R_lat=1: every accept goes to FIRE; maximum throughput is one sample per 3 cycles plus handshake wait.
REQ-027 comb_in holds its value outside COUNT-captures; it is never modified in FIRE or HOLD.
REQ-028 Phase counter is RateBits wide and never exceeds R_lat.

Reset
REQ-029 rst_n low asynchronously forces IDLE, phase=0, R_lat=1, comb_in=0, comb_in_valid=0, in_ready=0, overrun_count=0.
REQ-030 Reset mid-FIRE or mid-HOLD abandons the sample; there is no pending state after release.

Configuration
REQ-031 Macro CIC_DECIM_CTRL_OVERRUN_COUNT_EN: when defined, overrun_count increments on every cycle with in_valid=1 and in_ready=0 outside IDLE, saturating at 16'hFFFF.
REQ-032 Without the macro, overrun_count is constant 0 and no counter register is built.

Structure
REQ-033 Package cic_pkg holds the state enum typedef (cic_decim_state_t) and constant DefaultRateBits=8.
REQ-034 Single module; no sub-module required; comb port names match the existing comb handshake.

Verification
REQ-035 rst_n=0 held for 1000 cycles, enable=1, in_valid=1 -> in_ready=0, comb_in_valid=0, comb_in=0 throughout.
REQ-036 rate=4, in=1,2,3,...,12 every cycle, out_ready=1, comb looped back with 1-cycle valid -> comb_in_valid pulses with comb_in=4, 8, 12.
REQ-037 rate=0, in=7 -> treated as R=1; comb_in_valid follows each accept with comb_in=7.
REQ-038 rate=3, out_ready=0 after first FIRE -> state stays HOLD, in_ready=0 for 100 cycles; out_ready=1 for one cycle -> COUNT next cycle.
REQ-039 rate changed 4->2 after 2 accepts -> next decimated sample still on 4th accept; R=2 only after an enable low/high cycle.
REQ-040 With the macro defined, in_valid=1 for 5 cycles in HOLD -> overrun_count=5; without the macro -> overrun_count=0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimation controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cic_pkg;

    localparam int DefaultRateBits = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2,
        HOLD  = 2'd3
    } cic_decim_state_t;

endpackage

// File: rtl/cic_decim_ctrl.sv
// Decimation controller: keeps every R-th accepted integrator sample and hands it to the comb stage.
// Latency: the R-th accept at edge N raises comb_in_valid during cycle N+1; in_ready is registered.
// Backpressure: in_ready drops from the R-th accept until the comb output handshakes (optional overrun counter: CIC_DECIM_CTRL_OVERRUN_COUNT_EN).
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int WordLengthBits = 12,
    parameter int RateBits       = DefaultRateBits
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic        [RateBits-1:0]       rate,
    input  logic signed [WordLengthBits-1:0] in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic signed [WordLengthBits-1:0] comb_in,
    output logic                             comb_in_valid,
    input  logic                             comb_out_valid,
    output logic                             comb_out_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic        [15:0]               overrun_count
);

    localparam logic [RateBits-1:0] PhaseOne = RateBits'(1);

    cic_decim_state_t    state;
    logic [RateBits-1:0] phase;
    logic [RateBits-1:0] r_lat;
    logic [RateBits-1:0] phase_next;

    // The comb output handshake passes straight through.
    assign comb_out_ready = out_ready;
    assign out_valid      = comb_out_valid;

    // phase never exceeds r_lat, so phase+1 cannot wrap.
    assign phase_next = phase + PhaseOne;

    // Control FSM; in_ready and comb_in_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= '0;
            r_lat         <= PhaseOne;
            comb_in       <= '0;
            comb_in_valid <= 1'b0;
            in_ready      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    comb_in_valid <= 1'b0;
                    if (enable) begin
                        // rate is only sampled here; later changes wait for the next run.
                        r_lat    <= (rate == '0) ? PhaseOne : rate;
                        phase    <= '0;
                        state    <= COUNT;
                        in_ready <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        // Abandon the partial group.
                        phase    <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b0;
                    end else if (in_valid) begin
                        if (phase_next == r_lat) begin
                            comb_in       <= in;
                            phase         <= '0;
                            state         <= FIRE;
                            comb_in_valid <= 1'b1;
                            in_ready      <= 1'b0;
                        end else begin
                            phase <= phase_next;
                        end
                    end
                end
                FIRE: begin
                    comb_in_valid <= 1'b0;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (comb_out_valid && out_ready) begin
                        if (enable) begin
                            state    <= COUNT;
                            in_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    phase         <= '0;
                    comb_in_valid <= 1'b0;
                    in_ready      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CIC_DECIM_CTRL_OVERRUN_COUNT_EN
    logic [15:0] overrun_q;

    // Count cycles where a sample is offered but cannot be taken while running; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 16'h0000;
        end else if ((state != IDLE) && in_valid && !in_ready && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign overrun_count = overrun_q;
`else
    assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl with a transaction-level reference model.
// Latency: n/a.
// Backpressure: a small comb stand-in holds its output valid until out_ready.
module tb_cic_decim_ctrl;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [7:0]         rate;
    logic signed [11:0] din;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] comb_in;
    logic               comb_in_valid;
    logic               comb_out_valid;
    logic               comb_out_ready;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        overrun_count;

    int chk_cnt;
    int fail_cnt;

    cic_decim_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .rate           (rate),
        .in             (din),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .comb_in        (comb_in),
        .comb_in_valid  (comb_in_valid),
        .comb_out_valid (comb_out_valid),
        .comb_out_ready (comb_out_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overrun_count  (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Comb stand-in: one sample in flight, output held until taken.
    logic pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       pend <= 1'b0;
        else if (comb_in_valid)           pend <= 1'b1;
        else if (pend && comb_out_ready)  pend <= 1'b0;
    end
    assign comb_out_valid = pend;

    // Reference model: run flag, latched ratio, accepts in current group,
    // waiting-for-comb flag, strobe due this cycle, expected held sample.
    logic               m_active;
    logic               m_busy;
    logic               m_fire;
    int                 m_rlat;
    int                 m_cnt;
    logic signed [11:0] m_comb;
    int                 m_ovr;
    logic signed [11:0] fired_q[$];

    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n) begin
            m_active = 1'b0; m_busy = 1'b0; m_fire = 1'b0;
            m_rlat = 1; m_cnt = 0; m_comb = '0; m_ovr = 0;
        end
        exp_rdy = m_active && !m_busy;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("comb_in_valid", 32'(comb_in_valid), 32'(m_fire));
        check_eq("comb_in", 32'(comb_in), 32'(m_comb));
        check_eq("overrun_count", 32'(overrun_count), m_ovr);
        check_eq("out_valid", 32'(out_valid), 32'(comb_out_valid));
        check_eq("comb_out_ready", 32'(comb_out_ready), 32'(out_ready));
        if (comb_in_valid) fired_q.push_back(comb_in);
        if (rst_n) begin
`ifdef CIC_DECIM_CTRL_OVERRUN_COUNT_EN
            if (m_active && in_valid && !exp_rdy && m_ovr < 65535) m_ovr++;
`endif
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_rlat   = (rate == 8'd0) ? 1 : int'(rate);
                    m_cnt    = 0;
                end
            end else if (m_busy) begin
                if (m_fire) begin
                    m_fire = 1'b0;
                end else if (comb_out_valid && out_ready) begin
                    m_busy   = 1'b0;
                    m_active = enable;
                    m_cnt    = 0;
                end
            end else begin
                if (!enable) begin
                    m_active = 1'b0;
                    m_cnt    = 0;
                end else if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == m_rlat) begin
                        m_busy = 1'b1;
                        m_fire = 1'b1;
                        m_comb = din;
                        m_cnt  = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one sample and wait (bounded) until it is taken; in_valid stays high.
    task automatic send(input logic signed [11:0] v);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        din = v;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic restart(input logic [7:0] r);
        in_valid = 1'b0;
        enable = 1'b0;
        tick(3);
        rate = r;
        enable = 1'b1;
        tick(2);
        fired_q.delete();
    endtask

    initial begin
        chk_cnt = 0;
        fail_cnt = 0;
        rst_n = 1'b0;
        enable = 1'b1;
        in_valid = 1'b1;
        rate = 8'd4;
        din = 12'sd5;
        out_ready = 1'b1;

        // Long reset with activity on the inputs.
        tick(1000);
        @(negedge clk);
        check_eq("rst_comb_in", 32'(comb_in), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ratio 4, samples 1..12 back to back.
        restart(8'd4);
        for (int i = 1; i <= 12; i++) send(12'(i));
        in_valid = 1'b0;
        tick(6);
        check_eq("r4_count", fired_q.size(), 3);
        if (fired_q.size() == 3) begin
            check_eq("r4_s0", 32'(fired_q[0]), 32'd4);
            check_eq("r4_s1", 32'(fired_q[1]), 32'd8);
            check_eq("r4_s2", 32'(fired_q[2]), 32'd12);
        end

        // Ratio 0 behaves as 1.
        restart(8'd0);
        for (int i = 0; i < 5; i++) send(12'sd7);
        in_valid = 1'b0;
        tick(6);
        check_eq("r0_count", fired_q.size(), 5);
        foreach (fired_q[i]) check_eq("r0_val", 32'(fired_q[i]), 32'd7);

        // Ratio 3 with downstream stalled after the first decimated sample.
        restart(8'd3);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send(12'(i * 10));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("stall_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(4);

        // Rate change mid-run is ignored until the next enable cycle.
        restart(8'd4);
        send(12'sd21); send(12'sd22);
        rate = 8'd2;
        send(12'sd23); send(12'sd24);
        in_valid = 1'b0;
        tick(5);
        send(12'sd25); send(12'sd26); send(12'sd27); send(12'sd28);
        in_valid = 1'b0;
        tick(5);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(2);
        send(12'sd29); send(12'sd30);
        in_valid = 1'b0;
        tick(5);
        check_eq("rchg_count", fired_q.size(), 3);
        if (fired_q.size() == 3) begin
            check_eq("rchg_s0", 32'(fired_q[0]), 32'd24);
            check_eq("rchg_s1", 32'(fired_q[1]), 32'd28);
            check_eq("rchg_s2", 32'(fired_q[2]), 32'd30);
        end

        // Overrun: five offered cycles while waiting in HOLD.
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        rate = 8'd1;
        out_ready = 1'b0;
        enable = 1'b1;
        tick(3);
        send(12'sd5);
        in_valid = 1'b0;
        tick(1);
        in_valid = 1'b1;
        tick(5);
        in_valid = 1'b0;
        @(negedge clk);
`ifdef CIC_DECIM_CTRL_OVERRUN_COUNT_EN
        check_eq("overrun_5", 32'(overrun_count), 32'd5);
`else
        check_eq("overrun_off", 32'(overrun_count), 32'd0);
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick(3);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            enable    = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 15) == 0) rate = 8'($urandom_range(0, 5));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            din       = 12'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
